// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master engine among NUM_REQ requesters.
// Optional watchdog abort enabled by defining I2C_ARB_WATCHDOG_EN.
module i2c_txn_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 65535,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         req_rw,
   input  logic [NUM_REQ*7-1:0]       req_addr,
   input  logic [NUM_REQ*8-1:0]       req_wdata,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [7:0]                 rsp_rdata,
   output logic                       rsp_err,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       drv_start,
   output logic                       drv_rw,
   output logic [6:0]                 drv_addr,
   output logic [7:0]                 drv_wdata,
   input  logic                       drv_busy,
   input  logic [7:0]                 drv_rdata
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int SW  = IDW + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARB    = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   logic [2:0]     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick;
   logic           rw_q, rw_d, err_q, err_d;
   logic [6:0]     addr_q, addr_d;
   logic [7:0]     wdata_q, wdata_d, rdata_q, rdata_d;
   logic [SW-1:0]  scan, nxt;
   logic           any_valid, idle_ok, timeout;

   assign any_valid = |req_valid;

`ifdef I2C_ARB_WATCHDOG_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Terminal value is one short so that exactly TIMEOUT_CYC cycles are spent in the phase.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   // An aborted transaction may leave the engine busy; never launch over it.
   assign idle_ok = !drv_busy;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != S_LAUNCH && state_d == S_LAUNCH) || (state_q != S_WAIT && state_d == S_WAIT))
         cnt_d = '0;
      else if (state_q == S_LAUNCH || state_q == S_WAIT)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{TIMEOUT_CYC, CNT_W};
   assign timeout    = 1'b0;
   assign idle_ok    = 1'b1;
`endif

   // First valid requester at or after ptr, wrapping; lowest offset wins.
   always_comb begin
      pick = ptr_q;
      scan = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan = {1'b0, ptr_q} + SW'(k);
         if (scan >= SW'(NUM_REQ)) scan = scan - SW'(NUM_REQ);
         if (req_valid[scan[IDW-1:0]]) pick = scan[IDW-1:0];
      end
      nxt = {1'b0, pick} + SW'(1);
      if (nxt >= SW'(NUM_REQ)) nxt = nxt - SW'(NUM_REQ);
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = '0;
      case (state_q)
         S_IDLE: if (any_valid && idle_ok) state_d = S_ARB;
         S_ARB: begin
            if (!any_valid) begin
               state_d = S_IDLE;
            end else begin
               req_ready[pick] = 1'b1;
               grant_d = pick;
               rw_d    = req_rw[pick];
               addr_d  = req_addr[7*pick +: 7];
               wdata_d = req_wdata[8*pick +: 8];
               ptr_d   = nxt[IDW-1:0];
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (drv_busy) begin
               state_d = S_WAIT;
            end else if (timeout) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               rdata_d = 8'h00;
            end
         end
         S_WAIT: begin
            if (!drv_busy) begin
               state_d = S_RESP;
               err_d   = 1'b0;
               rdata_d = rw_q ? drv_rdata : 8'h00;
            end else if (timeout) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               rdata_d = 8'h00;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      rsp_valid          = '0;
      rsp_valid[grant_q] = (state_q == S_RESP);
   end

   assign drv_start = (state_q == S_LAUNCH);
   assign drv_rw    = rw_q;
   assign drv_addr  = addr_q;
   assign drv_wdata = wdata_q;
   assign grant_id  = grant_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: behavioural reference model, engine model, directed + random stimulus.
module tb_i2c_txn_arbiter;
   localparam int N  = 4;
   localparam int TO = 100;
`ifdef I2C_ARB_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic           clk = 1'b0, rst = 1'b1;
   logic [N-1:0]   req_valid = '0, req_ready, req_rw = '0, rsp_valid;
   logic [N*7-1:0] req_addr = '0;
   logic [N*8-1:0] req_wdata = '0;
   logic [7:0]     rsp_rdata, drv_wdata, drv_rdata = '0;
   logic           rsp_err, drv_start, drv_rw, drv_busy = 1'b0;
   logic [1:0]     grant_id;
   logic [6:0]     drv_addr;

   i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .grant_id(grant_id), .drv_start(drv_start), .drv_rw(drv_rw),
      .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_busy(drv_busy), .drv_rdata(drv_rdata));

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int rr(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // Reference model: spec-level phase of the shared engine plus latched transaction.
   localparam int P_IDLE = 0, P_ARB = 1, P_LAUNCH = 2, P_WAIT = 3, P_RESP = 4;
   int ph = P_IDLE, m_ptr = 0, m_gid = 0, m_cnt = 0;
   logic m_rw = 0, m_err = 0;
   logic [6:0] m_addr = '0;
   logic [7:0] m_wd = '0, m_rd = '0;
   int lo_run = 0, hi_run = 0, last_hi = 0;
   int rdy_cnt [N];
   int gnt_q[$], rsp_id_q[$], rsp_dat_q[$], rsp_err_q[$];

   initial for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

   always @(negedge clk) begin
      logic [N-1:0] exp_rdy, exp_rv;
      int g;
      if (rst) begin
         chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, drv_start,
                               drv_rw, drv_addr, drv_wdata}, 64'd0);
         ph = P_IDLE; m_ptr = 0; m_gid = 0; m_cnt = 0; m_rw = 0; m_err = 0;
         m_addr = '0; m_wd = '0; m_rd = '0; lo_run = 0; hi_run = 0;
      end else begin
         exp_rdy = '0;
         if (ph == P_ARB && req_valid != '0) exp_rdy[rr(req_valid, m_ptr)] = 1'b1;
         exp_rv = '0;
         if (ph == P_RESP) exp_rv[m_gid] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         chk("rsp_valid", rsp_valid, exp_rv);
         if (ph == P_RESP) chk("rsp_err", rsp_err, m_err);
         chk("rsp_rdata", rsp_rdata, m_rd);
         chk("grant_id", grant_id, m_gid);
         chk("drv_start", drv_start, ph == P_LAUNCH);
         chk("drv_fields", {drv_rw, drv_addr, drv_wdata}, {m_rw, m_addr, m_wd});
         if (drv_start) begin
            if (hi_run == 0) chk("start_gap_ge2", lo_run >= 2, 1);
            hi_run++; lo_run = 0;
         end else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0; lo_run++;
         end
         for (int i = 0; i < N; i++) if (req_ready[i]) begin gnt_q.push_back(i); rdy_cnt[i]++; end
         for (int i = 0; i < N; i++) if (rsp_valid[i]) begin
            rsp_id_q.push_back(i); rsp_dat_q.push_back(rsp_rdata); rsp_err_q.push_back(rsp_err);
         end
         case (ph)
            P_IDLE: if (req_valid != '0 && (!WD || !drv_busy)) ph = P_ARB;
            P_ARB: begin
               if (req_valid == '0) ph = P_IDLE;
               else begin
                  g = rr(req_valid, m_ptr);
                  m_gid = g; m_ptr = (g + 1) % N;
                  m_rw = req_rw[g]; m_addr = req_addr[7*g +: 7]; m_wd = req_wdata[8*g +: 8];
                  ph = P_LAUNCH; m_cnt = 0;
               end
            end
            P_LAUNCH: begin
               if (drv_busy) begin ph = P_WAIT; m_cnt = 0; end
               else if (WD && m_cnt == TO - 1) begin ph = P_RESP; m_err = 1; m_rd = 0; end
               else m_cnt++;
            end
            P_WAIT: begin
               if (!drv_busy) begin ph = P_RESP; m_err = 0; m_rd = m_rw ? drv_rdata : 8'h00; end
               else if (WD && m_cnt == TO - 1) begin ph = P_RESP; m_err = 1; m_rd = 0; end
               else m_cnt++;
            end
            default: ph = P_IDLE;
         endcase
      end
   end

   // Engine model and requester behaviour, all driven from the main process.
   int  c_dly = 1, c_len = 3, e_wait = 0, e_len = 0;
   logic [7:0] c_rdata = 8'h00;
   bit  e_arm = 0, e_never = 0, rnd_eng = 0, st_prev = 0;
   int  rdy_ack [N];

   task automatic tick();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (rdy_cnt[i] != rdy_ack[i]) begin
         rdy_ack[i] = rdy_cnt[i]; req_valid[i] = 1'b0;
      end
      if (drv_start && !st_prev && !e_never) begin
         if (rnd_eng) begin
            c_dly = $urandom_range(0, 4); c_len = $urandom_range(1, 6); c_rdata = 8'($urandom);
         end
         e_arm = 1; e_wait = c_dly; e_len = c_len;
      end
      st_prev = drv_start;
      if (e_arm) begin
         if (e_wait > 0) e_wait--;
         else if (e_len > 0) begin drv_busy = 1'b1; e_len--; end
         else begin drv_busy = 1'b0; drv_rdata = c_rdata; e_arm = 0; end
      end
   endtask

   task automatic post(input int i, input logic rw, input logic [6:0] a, input logic [7:0] wd);
      req_valid[i] = 1'b1; req_rw[i] = rw; req_addr[7*i +: 7] = a; req_wdata[8*i +: 8] = wd;
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int k = 0;
      while (rsp_id_q.size() < n && k < budget) begin tick(); k++; end
      if (rsp_id_q.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL wait_rsp: actual %0d responses required %0d", rsp_id_q.size(), n);
      end
   endtask

   initial begin
      int base, rb, k;
      int np [N];
      int exp_order [8];
      for (int i = 0; i < N; i++) rdy_ack[i] = 0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // single write on requester 0
      c_dly = 3; c_len = 40;
      post(0, 1'b0, 7'h50, 8'hA5);
      wait_rsp(1, 200);
      chk("wr_grant", gnt_q[0], 0);
      chk("wr_ready_once", rdy_cnt[0], 1);
      chk("wr_addr", drv_addr, 7'h50);
      chk("wr_wdata", drv_wdata, 8'hA5);
      chk("wr_rsp_id", rsp_id_q[0], 0);
      chk("wr_rsp_err", rsp_err_q[0], 0);

      // single read on requester 2
      c_dly = 1; c_len = 5; c_rdata = 8'h7E;
      post(2, 1'b1, 7'h3C, 8'h00);
      wait_rsp(2, 200);
      chk("rd_rsp_id", rsp_id_q[1], 2);
      chk("rd_rdata", rsp_dat_q[1], 8'h7E);
      chk("rd_grant_id", grant_id, 2);

      // requester 3 alone, leaving the pointer at 0 for the contention run
      c_rdata = 8'h11;
      post(3, 1'b0, 7'h01, 8'h02);
      wait_rsp(3, 200);

      // contention: all four continuously valid for eight transactions
      c_dly = 1; c_len = 4;
      base = gnt_q.size(); rb = rsp_id_q.size();
      for (int i = 0; i < N; i++) begin post(i, i[0], 7'(8'h10 + i), 8'(i * 3)); np[i] = 1; end
      k = 0;
      while (rsp_id_q.size() < rb + 8 && k < 600) begin
         tick(); k++;
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && np[i] < 2) begin post(i, ~i[0], 7'(8'h20 + i), 8'(i * 5)); np[i]++; end
      end
      chk("cont_rsp_count", rsp_id_q.size(), rb + 8);
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int j = 0; j < 8; j++)
         if (gnt_q.size() > base + j) chk($sformatf("cont_order_%0d", j), gnt_q[base + j], exp_order[j]);

      // wrap-around: grant to 3, then requests on 1 and 0
      post(3, 1'b0, 7'h33, 8'h33);
      wait_rsp(rb + 9, 200);
      base = gnt_q.size();
      post(1, 1'b0, 7'h11, 8'h11);
      post(0, 1'b1, 7'h00, 8'h00);
      wait_rsp(rb + 11, 300);
      if (gnt_q.size() >= base + 2) begin
         chk("wrap_first", gnt_q[base], 0);
         chk("wrap_second", gnt_q[base + 1], 1);
      end

`ifdef I2C_ARB_WATCHDOG_EN
      // engine never goes busy: abort after TO launch cycles, then recover
      rb = rsp_id_q.size();
      e_never = 1;
      post(1, 1'b1, 7'h22, 8'h00);
      wait_rsp(rb + 1, 400);
      chk("wd_err", rsp_err_q[rb], 1);
      chk("wd_rdata", rsp_dat_q[rb], 0);
      chk("wd_launch_len", last_hi, TO);
      e_never = 0; c_rdata = 8'h5A;
      post(1, 1'b1, 7'h22, 8'h00);
      wait_rsp(rb + 2, 400);
      chk("wd_next_err", rsp_err_q[rb + 1], 0);
      chk("wd_next_rdata", rsp_dat_q[rb + 1], 8'h5A);
`endif

      // reset asserted during WAIT_DONE
      c_dly = 0; c_len = 60;
      post(2, 1'b0, 7'h44, 8'h44);
      k = 0;
      while (!drv_busy && k < 50) begin tick(); k++; end
      chk("rst_engine_busy", drv_busy, 1);
      tick(); tick(); tick();
      rb = rsp_id_q.size();
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", {drv_start, rsp_valid, req_ready, grant_id, drv_addr, rsp_rdata}, 64'd0);
      drv_busy = 1'b0; e_arm = 0; req_valid = '0;
      tick(); tick();
      rst = 1'b0;
      c_dly = 1; c_len = 2;
      base = gnt_q.size();
      for (int i = 0; i < N; i++) post(i, 1'b0, 7'(i), 8'(i));
      wait_rsp(rb + 4, 400);
      chk("rst_no_stale_rsp", rsp_id_q[rb], 0);
      chk("rst_first_grant", gnt_q[base], 0);

      // randomized traffic
      rnd_eng = 1;
      rb = rsp_id_q.size();
      for (int c = 0; c < 2000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0)
               post(i, 1'($urandom), 7'($urandom), 8'($urandom));
            else if (req_valid[i] && $urandom_range(0, 63) == 0)
               req_valid[i] = 1'b0;
         end
      end
      req_valid = '0;
      for (int c = 0; c < 40; c++) tick();
      chk("rand_activity", rsp_id_q.size() > rb + 50, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
